// File: rtl/debug_uart_pkg.sv
// Shared constants, state type and ASCII helper for the debug UART dump.
package debug_uart_pkg;

  localparam logic [7:0] ASCII_COLON   = 8'h3A;
  localparam logic [7:0] ASCII_SPACE   = 8'h20;
  localparam logic [7:0] ASCII_CR      = 8'h0D;
  localparam logic [7:0] ASCII_LF      = 8'h0A;
  localparam logic [7:0] ASCII_ZERO    = 8'h30;
  localparam logic [7:0] ASCII_UPPER_A = 8'h41;

  // Four words of "i:HHHHHHHH", three separating spaces, then CR LF.
  localparam int CHARS_PER_FRAME = 45;
  // Index digit, colon, eight hex digits and the trailing separator slot.
  localparam int CHARS_PER_WORD  = 11;

  typedef enum logic {
    ST_IDLE,
    ST_SEND
  } dump_state_e;

  // Map a 4-bit value to its uppercase ASCII hex digit.
  function automatic logic [7:0] nibble_to_ascii(input logic [3:0] nib);
    if (nib < 4'd10) begin
      return ASCII_ZERO + {4'd0, nib};
    end
    return ASCII_UPPER_A + {4'd0, nib} - 8'd10;
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// Byte-wide 8N1 transmitter. A start accepted on the done cycle chains the
// next character directly after the stop bit with no idle gap.
module uart_tx_byte #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] data,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] baud_q, baud_d;
  logic [3:0]    bit_q, bit_d;
  logic [7:0]    data_q, data_d;
  logic          tx_q, tx_d;
  logic          busy_q, busy_d;
  logic          bit_end;
  logic          accept;

  // Bit index 0 is the start bit, 1..8 the data bits, 9 the stop bit.
  assign bit_end = busy_q && (baud_q == BAUD_LAST);
  assign done    = bit_end && (bit_q == 4'd9);
  assign accept  = start && (!busy_q || done);
  assign tx      = tx_q;
  assign busy    = busy_q;

  // Next-state logic: tx_d is the level of the bit that begins next cycle.
  always_comb begin
    baud_d = baud_q;
    bit_d  = bit_q;
    data_d = data_q;
    tx_d   = tx_q;
    busy_d = busy_q;
    if (accept) begin
      busy_d = 1'b1;
      baud_d = '0;
      bit_d  = 4'd0;
      data_d = data;
      tx_d   = 1'b0;
    end else if (bit_end) begin
      baud_d = '0;
      if (bit_q == 4'd9) begin
        busy_d = 1'b0;
        bit_d  = 4'd0;
        tx_d   = 1'b1;
      end else begin
        bit_d = bit_q + 4'd1;
        tx_d  = (bit_q <= 4'd7) ? data_q[bit_q[2:0]] : 1'b1;
      end
    end else if (busy_q) begin
      baud_d = baud_q + 1'b1;
    end
  end

  // Register the transmitter state; the line idles high.
  always_ff @(posedge clk) begin
    if (rst) begin
      baud_q <= '0;
      bit_q  <= 4'd0;
      data_q <= 8'd0;
      tx_q   <= 1'b1;
      busy_q <= 1'b0;
    end else begin
      baud_q <= baud_d;
      bit_q  <= bit_d;
      data_q <= data_d;
      tx_q   <= tx_d;
      busy_q <= busy_d;
    end
  end

endmodule

// File: rtl/debug_uart_dump.sv
// Snapshots four debug words on a trigger rising edge and sends them as one
// ASCII hex line "0:HHHHHHHH 1:... 3:HHHHHHHH\r\n" over an 8N1 UART.
module debug_uart_dump
  import debug_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        trigger,
  input  logic [31:0] dbg0,
  input  logic [31:0] dbg1,
  input  logic [31:0] dbg2,
  input  logic [31:0] dbg3,
  output logic        tx,
  output logic        busy
);

  localparam logic [5:0] LAST_CHAR = 6'(CHARS_PER_FRAME - 1);

  dump_state_e      state_q, state_d;
  logic             trig_prev_q, trig_prev_d;
  logic             armed_q, armed_d;
  logic [5:0]       char_idx_q, char_idx_d;
  logic [3:0][31:0] snap_q, snap_d;

  logic       start_frame;
  logic       tx_start;
  logic       tx_busy;
  logic       tx_done;
  logic [5:0] sel_idx;
  logic [7:0] sel_char;
  logic [1:0] word_sel;
  logic [5:0] pos;
  logic [2:0] nib_idx;
  logic [31:0] shifted;

  // armed_q keeps a trigger held through reset from counting as a fresh edge.
  assign start_frame = (state_q == ST_IDLE) && !tx_busy && armed_q &&
                       trigger && !trig_prev_q;

  // State register plus edge detect, snapshot and character index.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      trig_prev_q <= 1'b0;
      armed_q     <= 1'b0;
      char_idx_q  <= 6'd0;
      snap_q      <= '0;
    end else begin
      state_q     <= state_d;
      trig_prev_q <= trig_prev_d;
      armed_q     <= armed_d;
      char_idx_q  <= char_idx_d;
      snap_q      <= snap_d;
    end
  end

  // Next state: leave SEND after the LF stop bit has finished.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start_frame) state_d = ST_SEND;
      ST_SEND: if (tx_done && (char_idx_q == LAST_CHAR)) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs and datapath: chain each character on the done of the previous one.
  always_comb begin
    trig_prev_d = trigger;
    armed_d     = 1'b1;
    char_idx_d  = char_idx_q;
    snap_d      = snap_q;
    tx_start    = 1'b0;
    sel_idx     = char_idx_q;
    busy        = (state_q == ST_SEND);
    if (start_frame) begin
      snap_d     = {dbg3, dbg2, dbg1, dbg0};
      char_idx_d = 6'd0;
      sel_idx    = 6'd0;
      tx_start   = 1'b1;
    end else if ((state_q == ST_SEND) && tx_done) begin
      if (char_idx_q == LAST_CHAR) begin
        char_idx_d = 6'd0;
      end else begin
        char_idx_d = char_idx_q + 6'd1;
        sel_idx    = char_idx_q + 6'd1;
        tx_start   = 1'b1;
      end
    end
  end

  // Character selection from the index and the snapshot words.
  always_comb begin
    word_sel = 2'd0;
    pos      = sel_idx;
    if (sel_idx >= 6'd33) begin
      word_sel = 2'd3;
      pos      = sel_idx - 6'd33;
    end else if (sel_idx >= 6'd22) begin
      word_sel = 2'd2;
      pos      = sel_idx - 6'd22;
    end else if (sel_idx >= 6'(CHARS_PER_WORD)) begin
      word_sel = 2'd1;
      pos      = sel_idx - 6'(CHARS_PER_WORD);
    end
    nib_idx = 3'(pos - 6'd2);
    shifted = snap_q[word_sel] << {nib_idx, 2'b00};
    if (sel_idx == LAST_CHAR - 6'd1) begin
      sel_char = ASCII_CR;
    end else if (sel_idx == LAST_CHAR) begin
      sel_char = ASCII_LF;
    end else if (pos == 6'd0) begin
      sel_char = ASCII_ZERO + {6'd0, word_sel};
    end else if (pos == 6'd1) begin
      sel_char = ASCII_COLON;
    end else if (pos == 6'd10) begin
      sel_char = ASCII_SPACE;
    end else begin
      sel_char = nibble_to_ascii(shifted[31:28]);
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx (
    .clk  (clk),
    .rst  (rst),
    .start(tx_start),
    .data (sel_char),
    .tx   (tx),
    .busy (tx_busy),
    .done (tx_done)
  );

endmodule

// File: tb/tb_debug_uart_dump.sv
// Bench for debug_uart_dump: frame-level model checked every cycle, a UART
// line decoder, and directed scenarios with literal expected lines.
module tb_debug_uart_dump;

  localparam int CPB          = 4;
  localparam int FRAME_CYCLES = 45 * 10 * CPB;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        trigger = 1'b1;
  logic [31:0] dbg0 = '0, dbg1 = '0, dbg2 = '0, dbg3 = '0;
  logic        tx, busy;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  debug_uart_dump #(.CLKS_PER_BIT(CPB)) dut (
    .clk    (clk),
    .rst    (rst),
    .trigger(trigger),
    .dbg0   (dbg0),
    .dbg1   (dbg1),
    .dbg2   (dbg2),
    .dbg3   (dbg3),
    .tx     (tx),
    .busy   (busy)
  );

  // Printable rendering of a line (control characters shown as <hh>).
  function automatic string vis(string s);
    string r = "";
    for (int i = 0; i < s.len(); i++) begin
      logic [7:0] c;
      c = s[i];
      if (c < 8'h20) r = $sformatf("%s<%02h>", r, c);
      else           r = $sformatf("%s%c", r, c);
    end
    return r;
  endfunction

  function automatic string crlf(string body);
    return $sformatf("%s%c%c", body, 8'h0D, 8'h0A);
  endfunction

  // Uppercase 8-digit hex of a word.
  function automatic string hex8(logic [31:0] w);
    string s;
    string r = "";
    s = $sformatf("%h", w);
    for (int i = 0; i < s.len(); i++) begin
      logic [7:0] c;
      c = s[i];
      if (c >= 8'h61 && c <= 8'h66) c = c - 8'd32;
      r = $sformatf("%s%c", r, c);
    end
    return r;
  endfunction

  function automatic string frame_text(logic [31:0] a, logic [31:0] b,
                                       logic [31:0] c, logic [31:0] d);
    return crlf($sformatf("0:%s 1:%s 2:%s 3:%s", hex8(a), hex8(b), hex8(c), hex8(d)));
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkText(input string name, input string act, input string exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got \"%s\", expected \"%s\"", name, vis(act), vis(exp));
    end
  endtask

  task automatic applyStimulus(input logic t, input logic r);
    @(negedge clk);
    #1;
    trigger = t;
    rst     = r;
  endtask

  task automatic setDbg(input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] c, input logic [31:0] d);
    @(negedge clk);
    #1;
    dbg0 = a; dbg1 = b; dbg2 = c; dbg3 = d;
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Frame-level model: when a frame starts, which line it carries, and
  // from elapsed time alone which UART bit must be on the line.
  string m_frame = "";
  bit    m_busy  = 1'b0;
  bit    m_prev  = 1'b0;
  bit    m_armed = 1'b0;
  bit    m_valid = 1'b0;
  int    m_elapsed = 0;

  always @(posedge clk) begin
    bit was_busy;
    if (rst) begin
      m_busy    = 1'b0;
      m_prev    = 1'b0;
      m_armed   = 1'b0;
      m_elapsed = 0;
    end else begin
      was_busy = m_busy;
      if (m_busy) begin
        m_elapsed++;
        if (m_elapsed == FRAME_CYCLES) m_busy = 1'b0;
      end
      if (trigger && !m_prev && !was_busy && m_armed) begin
        m_frame   = frame_text(dbg0, dbg1, dbg2, dbg3);
        m_busy    = 1'b1;
        m_elapsed = 0;
      end
      m_prev  = trigger;
      m_armed = 1'b1;
    end
    m_valid = 1'b1;
  end

  // Every cycle: tx and busy against the model.
  always @(negedge clk) begin
    if (m_valid) begin
      logic exp_tx;
      exp_tx = 1'b1;
      if (m_busy) begin
        int ci;
        int bi;
        logic [7:0] ch;
        ci = m_elapsed / (10 * CPB);
        bi = (m_elapsed / CPB) % 10;
        ch = m_frame[ci];
        if (bi == 0)      exp_tx = 1'b0;
        else if (bi == 9) exp_tx = 1'b1;
        else              exp_tx = ch[bi-1];
      end
      checkOutput("tx_busy_cycle", {30'd0, tx, busy}, {30'd0, exp_tx, m_busy});
    end
  end

  // UART decoder: mid-bit sampling, collects complete CR/LF-terminated lines.
  int         mon_cnt = 0;
  bit         mon_active = 1'b0;
  logic [7:0] mon_byte = 8'd0;
  string      rx_cur = "";
  string      rx_lines[$];
  int         framing_errs = 0;

  always @(negedge clk) begin
    if (rst === 1'b1) begin
      mon_active = 1'b0;
      rx_cur     = "";
    end else if (!mon_active) begin
      if (tx === 1'b0) begin
        mon_active = 1'b1;
        mon_cnt    = 0;
      end
    end else begin
      mon_cnt++;
      if (mon_cnt == CPB / 2 && tx !== 1'b0) framing_errs++;
      for (int j = 0; j < 8; j++) begin
        if (mon_cnt == CPB * (1 + j) + CPB / 2) mon_byte[j] = tx;
      end
      if (mon_cnt == 9 * CPB + CPB / 2) begin
        if (tx !== 1'b1) framing_errs++;
        rx_cur = $sformatf("%s%c", rx_cur, mon_byte);
        if (mon_byte == 8'h0A) begin
          rx_lines.push_back(rx_cur);
          rx_cur = "";
        end
      end
      if (mon_cnt == 10 * CPB - 1) mon_active = 1'b0;
    end
  end

  function automatic string line_at(int idx);
    if (idx < rx_lines.size()) return rx_lines[idx];
    return "<none>";
  endfunction

  // Start a frame from trigger low, check the first cycle, count busy cycles.
  // Returns on the first cycle with busy low.
  task automatic runFrame(input string tag, input bit scramble, output int n);
    applyStimulus(1'b1, 1'b0);
    @(negedge clk);
    checkOutput({tag, "_busy_first"}, busy, 1'b1);
    checkOutput({tag, "_tx_first"}, tx, 1'b0);
    n = 0;
    while (busy === 1'b1 && n < 4000) begin
      n++;
      if (n == 5) begin #1; trigger = 1'b0; end
      if (scramble && n == 10) begin
        #1;
        dbg0 = 32'hFFFFFFFF; dbg1 = 32'hFFFFFFFF;
        dbg2 = 32'hFFFFFFFF; dbg3 = 32'hFFFFFFFF;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    int hi;

    // Reset held three cycles with trigger high.
    tick(3);
    checkOutput("reset_tx", tx, 1'b1);
    checkOutput("reset_busy", busy, 1'b0);
    applyStimulus(1'b1, 1'b0);
    hi = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (busy !== 1'b0) hi++;
    end
    checkOutput("held_trigger_no_busy", hi, 0);
    checkOutput("held_trigger_no_line", rx_lines.size(), 0);
    applyStimulus(1'b0, 1'b0);
    tick(5);

    // Basic dump.
    setDbg(32'h00000004, 32'h00001000, 32'hDEADBEEF, 32'h12345678);
    runFrame("basic", 1'b0, n);
    checkOutput("basic_busy_len", n, FRAME_CYCLES);
    tick(3);
    checkOutput("basic_lines", rx_lines.size(), 1);
    checkText("basic_line", line_at(0), crlf("0:00000004 1:00001000 2:DEADBEEF 3:12345678"));

    // Inputs change mid-frame; the snapshot must hold.
    setDbg(32'h0123ABCD, 32'hCAFEF00D, 32'h00000000, 32'h89ABCDEF);
    tick(3);
    runFrame("snap", 1'b1, n);
    checkOutput("snap_busy_len", n, FRAME_CYCLES);
    tick(3);
    checkText("snap_line", line_at(1), crlf("0:0123ABCD 1:CAFEF00D 2:00000000 3:89ABCDEF"));

    // Edges while busy are dropped; a held level gives one frame.
    setDbg(32'hA5A5A5A5, 32'h0000FFFF, 32'h13579BDF, 32'h2468ACE0);
    applyStimulus(1'b1, 1'b0);
    tick(4);
    applyStimulus(1'b0, 1'b0);
    tick(493);
    applyStimulus(1'b1, 1'b0);
    tick(4);
    applyStimulus(1'b0, 1'b0);
    tick(95);
    applyStimulus(1'b1, 1'b0);
    tick(3000);
    applyStimulus(1'b0, 1'b0);
    tick(10);
    checkOutput("reject_lines", rx_lines.size(), 3);
    checkText("reject_line", line_at(2), crlf("0:A5A5A5A5 1:0000FFFF 2:13579BDF 3:2468ACE0"));
    checkOutput("reject_idle", busy, 1'b0);

    // Reset in the middle of a frame.
    setDbg(32'h00C0FFEE, 32'h0BADF00D, 32'h00000010, 32'hFFFFFFFE);
    applyStimulus(1'b1, 1'b0);
    tick(4);
    applyStimulus(1'b0, 1'b0);
    tick(694);
    applyStimulus(1'b0, 1'b1);
    @(negedge clk);
    checkOutput("midrst_tx", tx, 1'b1);
    checkOutput("midrst_busy", busy, 1'b0);
    applyStimulus(1'b0, 1'b0);
    tick(5);
    checkOutput("midrst_no_line", rx_lines.size(), 3);
    setDbg(32'hFEDCBA98, 32'h76543210, 32'h00000001, 32'h80000000);
    runFrame("after_rst", 1'b0, n);
    checkOutput("after_rst_busy_len", n, FRAME_CYCLES);
    tick(3);
    checkText("after_rst_line", line_at(3), crlf("0:FEDCBA98 1:76543210 2:00000001 3:80000000"));

    // Back-to-back: new edge on the very cycle busy falls.
    setDbg(32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444);
    runFrame("b2b_a", 1'b0, n);
    checkOutput("b2b_a_busy_len", n, FRAME_CYCLES);
    #1;
    dbg0 = 32'h55555555; dbg1 = 32'h66666666; dbg2 = 32'h77777777; dbg3 = 32'h8899AABB;
    trigger = 1'b1;
    @(negedge clk);
    checkOutput("b2b_restart_tx", tx, 1'b0);
    checkOutput("b2b_restart_busy", busy, 1'b1);
    n = 0;
    while (busy === 1'b1 && n < 4000) begin
      n++;
      if (n == 5) begin #1; trigger = 1'b0; end
      @(negedge clk);
    end
    checkOutput("b2b_b_busy_len", n, FRAME_CYCLES);
    tick(3);
    checkText("b2b_a_line", line_at(4), crlf("0:11111111 1:22222222 2:33333333 3:44444444"));
    checkText("b2b_b_line", line_at(5), crlf("0:55555555 1:66666666 2:77777777 3:8899AABB"));
    checkOutput("total_lines", rx_lines.size(), 6);
    checkOutput("framing_errors", framing_errs, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
